gb_cart_mem_arb: RTL and testbench
==================================

// Module: gb_cart_mem_arb
// PURPOSE
//  Single-port arbiter/sequencer for the external cartridge memory (PSRAM) behind the MBC.
//  Shares it between two requesters:
//   - CPU cartridge accesses: already-translated 24-bit MBC address.
//   - ROM-image loader: SD-card boot copy into memory.
//  Generates the memory strobe, handles fixed read latency, relocates cart RAM to RAM_BASE.
// PARAMETERS
//  MEM_LAT     2          memory read latency, cycles from mem_cs to valid mem_rdata (>=1)
//  RAM_BASE    24'hF00000 base address of cart RAM window in external memory
//  STARVE_MAX  4          consecutive CPU grants with ld_req pending before loader is forced
// PORTS
//  clock        in   1   system clock, all logic posedge
//  rst          in   1   synchronous, active-high reset
//  cpu_req      in   1   CPU request, level, held until cpu_ack
//  cpu_we       in   1   1=write, 0=read; stable while cpu_req
//  cpu_ram_sel  in   1   1=cart RAM access (A000-BFFF), 0=ROM
//  cpu_addr     in   24  MBC-translated address
//  cpu_wdata    in   8   write data
//  cpu_rdata    out  8   read data, valid when cpu_ack=1
//  cpu_ack      out  1   one-cycle completion pulse
//  ld_req       in   1   loader write request, level, held until ld_ack
//  ld_addr      in   24  loader absolute memory address
//  ld_wdata     in   8   loader write data
//  ld_ack       out  1   one-cycle completion pulse
//  mem_cs       out  1   memory strobe, one cycle per access
//  mem_we       out  1   write enable, qualified by mem_cs
//  mem_addr     out  24  memory address
//  mem_wdata    out  8   memory write data
//  mem_rdata    in   8   memory read data, MEM_LAT cycles after mem_cs
//  busy         out  1   1 when state != IDLE
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; state IDLE; starve_cnt 0; latency counter 0.
//   - Applies mid-access: strobe dropped, no ack, in-flight read discarded.
//  FSM states: IDLE, ISSUE, WAIT_RD, ACK.
//  IDLE:
//   - Arbitrate; on a grant, latch owner/we/addr/wdata and go to ISSUE.
//  ISSUE:
//   - mem_cs=1 for exactly one cycle; mem_we=latched we.
//   - Read -> WAIT_RD; write -> ACK.
//  WAIT_RD:
//   - Count MEM_LAT-1 cycles, then -> ACK.
//   - Capture mem_rdata on the cycle exactly MEM_LAT cycles after mem_cs.
//  ACK:
//   - Owner's ack=1 for one cycle; cpu_rdata driven from the capture register; -> IDLE.
//  Latency from grant to ack:
//   - read  = MEM_LAT+2 cycles
//   - write = 2 cycles
//   - min request-to-request period = ack + 1 IDLE cycle.
//  Requester rules:
//   - Request may drop or re-arm the cycle after ack.
//   - A request seen high in the ack cycle is not re-granted until IDLE.
//  Arbitration:
//   - CPU has priority.
//   - If ld_req and starve_cnt==STARVE_MAX, the loader wins a simultaneous request.
//   - starve_cnt increments on a CPU grant while ld_req=1.
//   - starve_cnt clears on a loader grant or when ld_req=0; it saturates.
//  Address mapping:
//   - cpu_ram_sel=1: mem_addr = RAM_BASE + {9'b0, cpu_addr[14:0]}.
//   - cpu_ram_sel=0: mem_addr = cpu_addr.
//   - Loader: mem_addr = ld_addr.
//   - All arithmetic 24-bit, wraps modulo 2^24.
//  Loader never reads: ld_req is always a write.
//  cpu_rdata holds its last value between acks.
// CONFIGURATION
//  Macro GB_CART_ROM_WP_EN:
//   - Defined: CPU write with cpu_ram_sel=0 is blocked (ROM write-protect).
//     No mem_cs; FSM goes IDLE->ACK directly; cpu_ack one cycle after grant.
//     Loader writes are unaffected.
//   - Undefined: such writes are forwarded as normal memory writes.
// STRUCTURE
//  Package gb_cart_pkg:
//   - arb_state_t enum {IDLE, ISSUE, WAIT_RD, ACK}
//   - owner_t enum {OWN_CPU, OWN_LD}
//   - localparam CART_AW=24, CART_DW=8
//  Single module, no sub-module. Latency and starvation counters are inline ($clog2-sized).
// TESTING
//  1. CPU read, addr 24'h004123, ram_sel=0, MEM_LAT=2, mem_rdata=8'h5A:
//     -> mem_cs one cycle at grant+1; cpu_ack at grant+4; cpu_rdata=8'h5A.
//  2. CPU write to RAM, addr 24'h0012AB, ram_sel=1, data 8'h77:
//     -> mem_addr=24'hF012AB, mem_we=1; cpu_ack at grant+2.
//  3. cpu_req and ld_req both held continuously, STARVE_MAX=4:
//     -> grant order CPU,CPU,CPU,CPU,LD, repeating; no ack lost.
//  4. rst asserted in the WAIT_RD cycle:
//     -> next cycle state IDLE, no cpu_ack.
//     Re-issued request completes with fresh data.
//  5. CPU write ram_sel=0, addr 24'h002000, data 8'h03:
//     -> with GB_CART_ROM_WP_EN: no mem_cs, cpu_ack at grant+1.
//     -> without it: mem_cs=1, mem_we=1.
//  6. Loader stream 256 bytes, ld_addr 24'h000000..0000FF:
//     -> 256 mem writes in order, each ld_ack once; busy=0 at end.

Source files
------------

// File: rtl/gb_cart_pkg.sv
// Shared types and widths for the cartridge memory arbiter.
package gb_cart_pkg;

   localparam int CART_AW = 24;
   localparam int CART_DW = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD,
      ACK
   } arb_state_t;

   typedef enum logic {
      OWN_CPU,
      OWN_LD
   } owner_t;

endpackage

// File: rtl/gb_cart_mem_arb.sv
// Single-port PSRAM arbiter/sequencer shared by CPU cart accesses and the ROM loader.
// Optional ROM write-protect of CPU writes is enabled by defining GB_CART_ROM_WP_EN.
module gb_cart_mem_arb
   import gb_cart_pkg::*;
#(
   parameter int                   MEM_LAT    = 2,
   parameter logic [CART_AW-1:0]   RAM_BASE   = 24'hF00000,
   parameter int                   STARVE_MAX = 4
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic                 cpu_ram_sel,
   input  logic [CART_AW-1:0]   cpu_addr,
   input  logic [CART_DW-1:0]   cpu_wdata,
   output logic [CART_DW-1:0]   cpu_rdata,
   output logic                 cpu_ack,
   input  logic                 ld_req,
   input  logic [CART_AW-1:0]   ld_addr,
   input  logic [CART_DW-1:0]   ld_wdata,
   output logic                 ld_ack,
   output logic                 mem_cs,
   output logic                 mem_we,
   output logic [CART_AW-1:0]   mem_addr,
   output logic [CART_DW-1:0]   mem_wdata,
   input  logic [CART_DW-1:0]   mem_rdata,
   output logic                 busy
);

   localparam int LAT_W = $clog2(MEM_LAT + 1);
   localparam int ST_W  = $clog2(STARVE_MAX + 1);

   arb_state_t           state;
   arb_state_t           state_next;
   owner_t               owner_q;
   logic                 we_q;
   logic [CART_AW-1:0]   addr_q;
   logic [CART_DW-1:0]   wdata_q;
   logic [CART_DW-1:0]   rdata_q;
   logic [LAT_W-1:0]     lat_cnt;
   logic [ST_W-1:0]      starve_cnt;
   logic                 grant_cpu;
   logic                 grant_ld;
   logic                 ld_win;
   logic                 lat_done;
   logic                 cpu_wp_block;
   logic [CART_AW-1:0]   cpu_mem_addr;

   // Cart RAM is relocated into its own window; ROM addresses pass straight through.
   assign cpu_mem_addr = cpu_ram_sel ? (RAM_BASE + {9'b0, cpu_addr[14:0]}) : cpu_addr;

`ifdef GB_CART_ROM_WP_EN
   assign cpu_wp_block = cpu_we & ~cpu_ram_sel;
`else
   assign cpu_wp_block = 1'b0;
`endif

   assign lat_done = (state == WAIT_RD) && (lat_cnt == LAT_W'(MEM_LAT - 1));

   always_ff @(posedge clock) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // The loader only beats the CPU once it has been passed over STARVE_MAX times in a row.
   always_comb begin
      state_next = state;
      grant_cpu  = 1'b0;
      grant_ld   = 1'b0;
      ld_win     = ld_req && (!cpu_req || (starve_cnt == ST_W'(STARVE_MAX)));
      unique case (state)
         IDLE: begin
            if (ld_win) begin
               grant_ld   = 1'b1;
               state_next = ISSUE;
            end else if (cpu_req) begin
               grant_cpu  = 1'b1;
               state_next = cpu_wp_block ? ACK : ISSUE;
            end
         end
         ISSUE:   state_next = we_q ? ACK : WAIT_RD;
         WAIT_RD: if (lat_done) state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         owner_q <= OWN_CPU;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant_ld) begin
         owner_q <= OWN_LD;
         we_q    <= 1'b1;
         addr_q  <= ld_addr;
         wdata_q <= ld_wdata;
      end else if (grant_cpu) begin
         owner_q <= OWN_CPU;
         we_q    <= cpu_we;
         addr_q  <= cpu_mem_addr;
         wdata_q <= cpu_wdata;
      end
   end

   // The capture lands on the last WAIT_RD cycle, exactly MEM_LAT cycles after the strobe.
   always_ff @(posedge clock) begin
      if (rst) begin
         lat_cnt <= '0;
         rdata_q <= '0;
      end else begin
         if (state == WAIT_RD && !lat_done) lat_cnt <= lat_cnt + 1'b1;
         else                               lat_cnt <= '0;
         if (lat_done) rdata_q <= mem_rdata;
      end
   end

   always_ff @(posedge clock) begin
      if (rst || !ld_req || grant_ld)                          starve_cnt <= '0;
      else if (grant_cpu && starve_cnt != ST_W'(STARVE_MAX))   starve_cnt <= starve_cnt + 1'b1;
   end

   assign mem_cs    = (state == ISSUE);
   assign mem_we    = (state == ISSUE) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_ack   = (state == ACK) && (owner_q == OWN_CPU);
   assign ld_ack    = (state == ACK) && (owner_q == OWN_LD);
   assign cpu_rdata = rdata_q;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gb_cart_mem_arb.sv
// Directed self-checking bench for gb_cart_mem_arb with a fixed-latency memory model.
module tb_gb_cart_mem_arb;

   localparam int MEM_LAT = 2;

   logic         clock;
   logic         rst;
   logic         cpu_req;
   logic         cpu_we;
   logic         cpu_ram_sel;
   logic [23:0]  cpu_addr;
   logic [7:0]   cpu_wdata;
   logic [7:0]   cpu_rdata;
   logic         cpu_ack;
   logic         ld_req;
   logic [23:0]  ld_addr;
   logic [7:0]   ld_wdata;
   logic         ld_ack;
   logic         mem_cs;
   logic         mem_we;
   logic [23:0]  mem_addr;
   logic [7:0]   mem_wdata;
   logic [7:0]   mem_rdata;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0]          rd_val = 8'h00;
   logic [MEM_LAT-1:0]  cs_pipe = '0;
   int                  cs_cnt = 0;
   int                  ld_ack_cnt = 0;
   logic [31:0]         wr_log[$];

   gb_cart_mem_arb #(
      .MEM_LAT    (MEM_LAT),
      .RAM_BASE   (24'hF00000),
      .STARVE_MAX (4)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_ram_sel (cpu_ram_sel),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ack     (cpu_ack),
      .ld_req      (ld_req),
      .ld_addr     (ld_addr),
      .ld_wdata    (ld_wdata),
      .ld_ack      (ld_ack),
      .mem_cs      (mem_cs),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .busy        (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory model: read data is valid only in the cycle exactly MEM_LAT after the strobe.
   always @(posedge clock) begin
      cs_pipe <= {cs_pipe[MEM_LAT-2:0], mem_cs};
      if (mem_cs) cs_cnt <= cs_cnt + 1;
      if (ld_ack) ld_ack_cnt <= ld_ack_cnt + 1;
      if (mem_cs && mem_we) wr_log.push_back({mem_addr, mem_wdata});
   end
   assign mem_rdata = cs_pipe[MEM_LAT-1] ? rd_val : 8'hEE;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic creq, input logic cwe, input logic csel,
                                input logic [23:0] caddr, input logic [7:0] cdata,
                                input logic lreq, input logic [23:0] laddr, input logic [7:0] ldata);
      cpu_req     = creq;
      cpu_we      = cwe;
      cpu_ram_sel = csel;
      cpu_addr    = caddr;
      cpu_wdata   = cdata;
      ld_req      = lreq;
      ld_addr     = laddr;
      ld_wdata    = ldata;
   endtask

   task automatic waitAck(input bit forLd, input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (((forLd ? ld_ack : cpu_ack) !== 1'b1) && n < limit);
      if ((forLd ? ld_ack : cpu_ack) !== 1'b1) n = limit + 1;
   endtask

   task automatic waitAnyAck(input int limit, output int who);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (cpu_ack !== 1'b1 && ld_ack !== 1'b1 && n < limit);
      if (cpu_ack === 1'b1 && ld_ack === 1'b1) who = 3;
      else if (cpu_ack === 1'b1)               who = 0;
      else if (ld_ack === 1'b1)                who = 1;
      else                                     who = 2;
   endtask

   initial begin
      int n;
      int who;
      int c0;
      int bad;
      logic [31:0] exp_wr;

      rst = 1'b1;
      applyStimulus(0, 0, 0, 24'h0, 8'h0, 0, 24'h0, 8'h0);
      tick();
      tick();
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_mem_cs", mem_cs, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_acks", {cpu_ack, ld_ack}, 0);
      checkOutput("rst_cpu_rdata", cpu_rdata, 0);
      rst = 1'b0;
      tick();

      // CPU ROM read
      c0 = cs_cnt;
      rd_val = 8'h5A;
      applyStimulus(1, 0, 0, 24'h004123, 8'h00, 0, 24'h0, 8'h0);
      tick();
      checkOutput("rd_cs_g1", {mem_cs, mem_we}, 2'b10);
      checkOutput("rd_addr", mem_addr, 24'h004123);
      checkOutput("rd_busy", busy, 1);
      tick();
      checkOutput("rd_g2", {mem_cs, cpu_ack}, 0);
      tick();
      checkOutput("rd_g3_ack", cpu_ack, 0);
      tick();
      checkOutput("rd_g4_ack", {cpu_ack, ld_ack}, 2'b10);
      checkOutput("rd_data", cpu_rdata, 8'h5A);
      applyStimulus(0, 0, 0, 24'h0, 8'h0, 0, 24'h0, 8'h0);
      tick();
      checkOutput("rd_idle", {busy, cpu_ack}, 0);
      checkOutput("rd_hold", cpu_rdata, 8'h5A);
      checkOutput("rd_cs_count", cs_cnt - c0, 1);

      // CPU write to cart RAM
      applyStimulus(1, 1, 1, 24'h0012AB, 8'h77, 0, 24'h0, 8'h0);
      tick();
      checkOutput("wr_cs_we", {mem_cs, mem_we}, 2'b11);
      checkOutput("wr_ram_addr", mem_addr, 24'hF012AB);
      checkOutput("wr_wdata", mem_wdata, 8'h77);
      tick();
      checkOutput("wr_ack_g2", cpu_ack, 1);
      checkOutput("wr_rdata_hold", cpu_rdata, 8'h5A);
      applyStimulus(0, 0, 0, 24'h0, 8'h0, 0, 24'h0, 8'h0);
      tick();

      // CPU write to ROM space
      c0 = cs_cnt;
      applyStimulus(1, 1, 0, 24'h002000, 8'h03, 0, 24'h0, 8'h0);
      tick();
`ifdef GB_CART_ROM_WP_EN
      checkOutput("wp_no_cs", mem_cs, 0);
      checkOutput("wp_ack_g1", cpu_ack, 1);
`else
      checkOutput("rom_wr_cs_we", {mem_cs, mem_we}, 2'b11);
      checkOutput("rom_wr_addr", mem_addr, 24'h002000);
      tick();
      checkOutput("rom_wr_ack", cpu_ack, 1);
`endif
      applyStimulus(0, 0, 0, 24'h0, 8'h0, 0, 24'h0, 8'h0);
      tick();
`ifdef GB_CART_ROM_WP_EN
      checkOutput("wp_cs_count", cs_cnt - c0, 0);
`else
      checkOutput("rom_wr_cs_count", cs_cnt - c0, 1);
`endif

      // Both requesters held: loader forced in after four CPU grants
      applyStimulus(1, 1, 1, 24'h000010, 8'h44, 1, 24'h0000AA, 8'h99);
      for (int k = 0; k < 10; k++) begin
         waitAnyAck(6, who);
         checkOutput($sformatf("starve_order_%0d", k), who, (k % 5 == 4) ? 1 : 0);
      end
      applyStimulus(0, 0, 0, 24'h0, 8'h0, 0, 24'h0, 8'h0);
      tick();
      checkOutput("starve_idle", busy, 0);

      // Reset during WAIT_RD discards the read; reissue gets fresh data
      rd_val = 8'h11;
      applyStimulus(1, 0, 0, 24'h000100, 8'h00, 0, 24'h0, 8'h0);
      tick();
      tick();
      checkOutput("rstmid_in_wait", {busy, mem_cs}, 2'b10);
      rst = 1'b1;
      tick();
      checkOutput("rstmid_idle", {busy, cpu_ack, mem_cs}, 0);
      checkOutput("rstmid_rdata", cpu_rdata, 8'h00);
      rst = 1'b0;
      rd_val = 8'h22;
      waitAck(0, 8, n);
      checkOutput("rstmid_reissue_lat", n, 4);
      checkOutput("rstmid_fresh", cpu_rdata, 8'h22);
      applyStimulus(0, 0, 0, 24'h0, 8'h0, 0, 24'h0, 8'h0);
      tick();

      // Loader stream of 256 bytes
      wr_log.delete();
      c0  = ld_ack_cnt;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(0, 0, 0, 24'h0, 8'h0, 1, 24'(i), 8'(i) ^ 8'hA5);
         waitAck(1, 6, n);
         if (n != 2) bad++;
         applyStimulus(0, 0, 0, 24'h0, 8'h0, 0, 24'h0, 8'h0);
         tick();
      end
      checkOutput("ld_latency_bad", bad, 0);
      checkOutput("ld_write_count", wr_log.size(), 256);
      checkOutput("ld_ack_count", ld_ack_cnt - c0, 256);
      bad = 0;
      for (int i = 0; i < 256 && i < wr_log.size(); i++) begin
         exp_wr = {24'(i), 8'(i) ^ 8'hA5};
         if (wr_log[i] !== exp_wr) bad++;
      end
      checkOutput("ld_order_bad", bad, 0);
      checkOutput("ld_end_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
